pc_gen: RTL and testbench

Parametrised program-counter generator for the five-stage pipeline. Successor to the combinational next-PC select: it owns the PC register and arbitrates any number of prioritised redirect sources (trap, jump, branch, ...). It holds redirects that arrive while fetch is stalled, and traps misaligned targets to a fixed vector. It sits at the front of IF and drives the instruction-memory address and the front-end flush.

---
 rtl/pc_gen.sv | 126 ++++++++++++
 tb/tb_pc_gen.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Program-counter generator: owns the fetch PC, arbitrates prioritised redirect
// sources, holds a redirect across fetch stalls and traps misaligned targets.
module pc_gen #(
  parameter int unsigned         PC_WIDTH     = 64,
  parameter int unsigned         NUM_REDIRECT = 3,
  parameter int unsigned         INSTR_BYTES  = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
  parameter logic [PC_WIDTH-1:0] TRAP_VEC     = PC_WIDTH'(32'h100),
  localparam int unsigned        SRC_W        = (NUM_REDIRECT > 1) ? $clog2(NUM_REDIRECT) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall,
  input  logic [NUM_REDIRECT-1:0]          redirect_valid,
  input  logic [NUM_REDIRECT*PC_WIDTH-1:0] redirect_addr,
  output logic [PC_WIDTH-1:0]              pc,
  output logic                             flush,
  output logic [SRC_W-1:0]                 redirect_src,
  output logic                             pending,
  output logic                             misaligned,
  output logic [PC_WIDTH-1:0]              bad_addr
);

  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(INSTR_BYTES - 1);
  localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(INSTR_BYTES);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                flush_q, flush_d;
  logic [SRC_W-1:0]    src_q, src_d;
  logic                held_q, held_d;
  logic [SRC_W-1:0]    held_idx_q, held_idx_d;
  logic [PC_WIDTH-1:0] held_tgt_q, held_tgt_d;
  logic                mis_q, mis_d;
  logic [PC_WIDTH-1:0] bad_q, bad_d;

  logic                new_vld_s;
  logic [SRC_W-1:0]    new_idx_s;
  logic [PC_WIDTH-1:0] new_tgt_s;
  logic                take_new_s;
  logic                cand_vld_s;
  logic [SRC_W-1:0]    cand_idx_s;
  logic [PC_WIDTH-1:0] cand_tgt_s;

  // Lowest-index valid source wins; the descending scan lets it overwrite the rest.
  always_comb begin
    new_vld_s = 1'b0;
    new_idx_s = '0;
    new_tgt_s = '0;
    for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
      new_idx_s = redirect_valid[i] ? SRC_W'(i) : new_idx_s;
      new_tgt_s = redirect_valid[i] ? redirect_addr[i*PC_WIDTH +: PC_WIDTH] : new_tgt_s;
      new_vld_s = new_vld_s | redirect_valid[i];
    end
  end

  // Next-state selection for PC, held redirect and trap reporting.
  always_comb begin
    pc_d       = pc_q;
    flush_d    = 1'b0;
    src_d      = src_q;
    held_d     = held_q;
    held_idx_d = held_idx_q;
    held_tgt_d = held_tgt_q;
    mis_d      = 1'b0;
    bad_d      = bad_q;

    take_new_s = new_vld_s && (!held_q || (new_idx_s <= held_idx_q));
    cand_vld_s = take_new_s || held_q;
    cand_idx_s = take_new_s ? new_idx_s : held_idx_q;
    cand_tgt_s = take_new_s ? new_tgt_s : held_tgt_q;

    if (stall) begin
      if (take_new_s) begin
        held_d     = 1'b1;
        held_idx_d = new_idx_s;
        held_tgt_d = new_tgt_s;
      end else begin
        held_d     = held_q;
      end
    end else if (cand_vld_s) begin
      held_d  = 1'b0;
      flush_d = 1'b1;
      src_d   = cand_idx_s;
      if ((cand_tgt_s & ALIGN_MASK) == '0) begin
        pc_d = cand_tgt_s;
      end else begin
        pc_d  = TRAP_VEC;
        mis_d = 1'b1;
        bad_d = cand_tgt_s;
      end
    end else begin
      pc_d = pc_q + STEP;
    end
  end

  // State registers; reset dominates and discards any held redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      flush_q    <= 1'b0;
      src_q      <= '0;
      held_q     <= 1'b0;
      held_idx_q <= '0;
      held_tgt_q <= '0;
      mis_q      <= 1'b0;
      bad_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      src_q      <= src_d;
      held_q     <= held_d;
      held_idx_q <= held_idx_d;
      held_tgt_q <= held_tgt_d;
      mis_q      <= mis_d;
      bad_q      <= bad_d;
    end
  end

  assign pc           = pc_q;
  assign flush        = flush_q;
  assign redirect_src = src_q;
  assign pending      = held_q;
  assign misaligned   = mis_q;
  assign bad_addr     = bad_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// compared against a behavioural model of the fetch PC.
module tb_pc_gen;

  logic         clk;
  logic         rst;
  logic         stall;
  logic [2:0]   redirect_valid;
  logic [191:0] redirect_addr;
  logic [63:0]  pc;
  logic         flush;
  logic [1:0]   redirect_src;
  logic         pending;
  logic         misaligned;
  logic [63:0]  bad_addr;

  int errors = 0;
  int checks = 0;

  // behavioural model state
  logic [63:0] m_pc, m_bad, m_htgt;
  logic        m_flush, m_mis, m_held;
  int          m_src, m_hidx;

  pc_gen dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .pc(pc), .flush(flush), .redirect_src(redirect_src),
    .pending(pending), .misaligned(misaligned), .bad_addr(bad_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model, then wait past the edge.
  task automatic step(input logic r, input logic s, input logic [2:0] v,
                      input logic [63:0] a0, input logic [63:0] a1, input logic [63:0] a2);
    logic [63:0] addr [3];
    logic [63:0] tgt;
    int ni, idx;
    bit use_new;
    addr[0] = a0; addr[1] = a1; addr[2] = a2;
    ni = -1;
    for (int i = 2; i >= 0; i--) if (v[i]) ni = i;
    rst = r; stall = s; redirect_valid = v; redirect_addr = {a2, a1, a0};
    if (r) begin
      m_pc = 64'd0; m_flush = 1'b0; m_src = 0; m_held = 1'b0; m_mis = 1'b0; m_bad = 64'd0;
    end else begin
      use_new = (ni >= 0) && (!m_held || ni <= m_hidx);
      if (s) begin
        if (use_new) begin m_held = 1'b1; m_hidx = ni; m_htgt = addr[ni]; end
        m_flush = 1'b0; m_mis = 1'b0;
      end else if (use_new || m_held) begin
        idx = use_new ? ni : m_hidx;
        tgt = use_new ? addr[ni] : m_htgt;
        m_held = 1'b0; m_flush = 1'b1; m_src = idx;
        if (tgt % 64'd4 == 64'd0) begin m_pc = tgt; m_mis = 1'b0; end
        else begin m_pc = 64'h100; m_mis = 1'b1; m_bad = tgt; end
      end else begin
        m_pc = m_pc + 64'd4; m_flush = 1'b0; m_mis = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 3'b000, 64'd0, 64'd0, 64'd0);
    step(1'b1, 1'b1, 3'b111, 64'h10, 64'h20, 64'h30);
    checks++; if (pc !== 64'd0) begin errors++; $display("FAIL reset_pc got=%h exp=0", pc); end
    checks++; if ({flush, pending, misaligned} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {flush, pending, misaligned}); end
    checks++; if (redirect_src !== 2'd0 || bad_addr !== 64'd0) begin errors++; $display("FAIL reset_src_bad got=%0d/%h exp=0/0", redirect_src, bad_addr); end
  endtask

  task automatic test_sequential();
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 64'd0);
      checks++; if (pc !== 64'(4 * k) || flush !== 1'b0) begin errors++; $display("FAIL seq_pc got=%h/%b exp=%h/0", pc, flush, 64'(4 * k)); end
    end
  endtask

  task automatic test_priority();
    step(1'b0, 1'b0, 3'b011, 64'h200, 64'h300, 64'd0);
    checks++; if (pc !== 64'h200 || flush !== 1'b1 || redirect_src !== 2'd0) begin errors++; $display("FAIL prio got=%h/%b/%0d exp=200/1/0", pc, flush, redirect_src); end
    step(1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 64'd0);
    checks++; if (pc !== 64'h204 || flush !== 1'b0) begin errors++; $display("FAIL prio_next got=%h/%b exp=204/0", pc, flush); end
  endtask

  task automatic test_stall_capture(input bit src1_first);
    logic [63:0] held_pc;
    held_pc = pc;
    if (src1_first) step(1'b0, 1'b1, 3'b010, 64'd0, 64'h500, 64'd0);
    else            step(1'b0, 1'b1, 3'b100, 64'd0, 64'd0, 64'h400);
    checks++; if (pc !== held_pc || pending !== 1'b1 || flush !== 1'b0) begin errors++; $display("FAIL stall_c1 got=%h/%b/%b exp=%h/1/0", pc, pending, flush, held_pc); end
    if (src1_first) step(1'b0, 1'b1, 3'b100, 64'd0, 64'd0, 64'h400);
    else            step(1'b0, 1'b1, 3'b010, 64'd0, 64'h500, 64'd0);
    step(1'b0, 1'b1, 3'b000, 64'd0, 64'd0, 64'd0);
    checks++; if (pc !== held_pc || pending !== 1'b1) begin errors++; $display("FAIL stall_c3 got=%h/%b exp=%h/1", pc, pending, held_pc); end
    step(1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 64'd0);
    checks++; if (pc !== 64'h500 || flush !== 1'b1 || redirect_src !== 2'd1 || pending !== 1'b0) begin errors++; $display("FAIL stall_release got=%h/%b/%0d/%b exp=500/1/1/0", pc, flush, redirect_src, pending); end
  endtask

  task automatic test_misaligned();
    step(1'b0, 1'b0, 3'b001, 64'h402, 64'd0, 64'd0);
    checks++; if (pc !== 64'h100 || flush !== 1'b1 || misaligned !== 1'b1 || bad_addr !== 64'h402) begin errors++; $display("FAIL misal got=%h/%b/%b/%h exp=100/1/1/402", pc, flush, misaligned, bad_addr); end
    step(1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 64'd0);
    checks++; if (pc !== 64'h104 || misaligned !== 1'b0 || flush !== 1'b0 || bad_addr !== 64'h402) begin errors++; $display("FAIL misal_after got=%h/%b/%b/%h exp=104/0/0/402", pc, misaligned, flush, bad_addr); end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b0, 3'b001, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0);
    checks++; if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_load got=%h exp=fffffffffffffffc", pc); end
    step(1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 64'd0);
    checks++; if (pc !== 64'd0 || flush !== 1'b0 || misaligned !== 1'b0) begin errors++; $display("FAIL wrap got=%h/%b/%b exp=0/0/0", pc, flush, misaligned); end
  endtask

  task automatic test_reset_pending();
    step(1'b0, 1'b1, 3'b001, 64'h600, 64'd0, 64'd0);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL rstpend_cap got=%b exp=1", pending); end
    step(1'b1, 1'b1, 3'b000, 64'd0, 64'd0, 64'd0);
    checks++; if (pc !== 64'd0 || pending !== 1'b0) begin errors++; $display("FAIL rstpend_rst got=%h/%b exp=0/0", pc, pending); end
    step(1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 64'd0);
    checks++; if (pc !== 64'd4 || flush !== 1'b0) begin errors++; $display("FAIL rstpend_after got=%h/%b exp=4/0", pc, flush); end
  endtask

  task automatic test_random();
    logic [63:0] a [3];
    logic [2:0]  v;
    logic        r, s;
    for (int n = 0; n < 400; n++) begin
      for (int j = 0; j < 3; j++) begin
        a[j] = {$urandom, $urandom};
        if ($urandom_range(0, 5) != 0) a[j][1:0] = 2'b00;
      end
      v = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      s = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 60) == 0);
      step(r, s, v, a[0], a[1], a[2]);
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, pc, m_pc); end
      checks++; if (flush !== m_flush || misaligned !== m_mis || pending !== m_held) begin errors++; $display("FAIL rnd_flags n=%0d got=%b%b%b exp=%b%b%b", n, flush, misaligned, pending, m_flush, m_mis, m_held); end
      checks++; if (bad_addr !== m_bad) begin errors++; $display("FAIL rnd_bad n=%0d got=%h exp=%h", n, bad_addr, m_bad); end
      if (m_flush) begin
        checks++; if (redirect_src !== 2'(m_src)) begin errors++; $display("FAIL rnd_src n=%0d got=%0d exp=%0d", n, redirect_src, m_src); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 3'b000; redirect_addr = '0;
    test_reset();
    test_sequential();
    test_priority();
    test_stall_capture(1'b0);
    test_stall_capture(1'b1);
    test_misaligned();
    test_wrap();
    test_reset_pending();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
